// File: rtl/store_buffer.sv
// Committed-store buffer: in-order FIFO of retired stores. It drains one store at a
// time to the D-cache store port and answers same-cycle load forwarding queries.
package Falco_pkg;
    typedef logic [31:0] mem_addr_t;
    typedef logic [31:0] xlen_data_t;

    typedef struct packed {
        logic       store_req;
        mem_addr_t  store_addr;
        xlen_data_t store_data;
        logic [3:0] store_mask;
    } core_store_req_t;

    typedef struct packed {
        logic store_finished;
        logic store_miss;
    } core_dcache_store_resp_t;
endpackage

module store_buffer
    import Falco_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_valid_i,
    input  logic [ADDR_W-1:0]       push_addr_i,
    input  logic [DATA_W-1:0]       push_data_i,
    input  logic [3:0]              push_mask_i,
    output logic                    push_ready_o,
    output core_store_req_t         dc_req_o,
    input  core_dcache_store_resp_t dc_resp_i,
    input  logic [ADDR_W-1:0]       ld_addr_i,
    output logic                    fwd_hit_o,
    output logic [DATA_W-1:0]       fwd_data_o,
    output logic                    ld_conflict_o,
    output logic                    sb_empty_o,
    output logic [31:0]             miss_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_MISS  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;

    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [3:0]         mask_q [DEPTH];

    logic               push_fire_s;
    logic               pop_s;
    logic               req_active_s;
    logic               fwd_found_s;
    logic [PTR_W-1:0]   fwd_sel_s;

    assign push_ready_o = (count_q != CNT_FULL);
    assign push_fire_s  = push_valid_i & push_ready_o;
    assign req_active_s = (state_q != S_IDLE);
    assign pop_s        = req_active_s & dc_resp_i.store_finished;
    assign sb_empty_o   = (count_q == CNT_ZERO);
    assign miss_cnt_o   = miss_cnt_q;

    // Occupancy and pointer next-state
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push_fire_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (push_fire_s) begin
            tail_d = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
    end

    // Drain FSM next-state; a simultaneous miss and finish counts as finished
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != CNT_ZERO) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (dc_resp_i.store_finished) begin
                    state_d = (count_d != CNT_ZERO) ? S_ISSUE : S_IDLE;
                end else if (dc_resp_i.store_miss) begin
                    state_d = S_MISS;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_MISS: begin
                if (dc_resp_i.store_finished) begin
                    state_d = (count_d != CNT_ZERO) ? S_ISSUE : S_IDLE;
                end else begin
                    state_d = S_MISS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating miss counter; pulses while idle are ignored
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (req_active_s && dc_resp_i.store_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= CNT_ZERO;
            miss_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Payload storage, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (push_fire_s) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
            mask_q[tail_q] <= push_mask_i;
        end
    end

    // Head entry to the D-cache; payload zeroed while no request is active
    always_comb begin
        dc_req_o           = '0;
        dc_req_o.store_req = req_active_s;
        if (req_active_s) begin
            dc_req_o.store_addr = addr_q[head_q];
            dc_req_o.store_data = data_q[head_q];
            dc_req_o.store_mask = mask_q[head_q];
        end else begin
            dc_req_o.store_addr = {ADDR_W{1'b0}};
            dc_req_o.store_data = {DATA_W{1'b0}};
            dc_req_o.store_mask = 4'h0;
        end
    end

    // Scan oldest to youngest so the last word match wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_found_s = 1'b0;
        fwd_sel_s   = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) &&
                (addr_q[idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2])) begin
                fwd_found_s = 1'b1;
                fwd_sel_s   = idx;
            end else begin
                fwd_found_s = fwd_found_s;
                fwd_sel_s   = fwd_sel_s;
            end
        end
    end

    // Forwarding outputs from the selected entry
    always_comb begin
        fwd_hit_o     = 1'b0;
        ld_conflict_o = 1'b0;
        fwd_data_o    = {DATA_W{1'b0}};
        if (fwd_found_s) begin
            fwd_hit_o     = (mask_q[fwd_sel_s] == 4'hF);
            ld_conflict_o = (mask_q[fwd_sel_s] != 4'hF) && (mask_q[fwd_sel_s] != 4'h0);
            fwd_data_o    = (mask_q[fwd_sel_s] == 4'hF) ? data_q[fwd_sel_s] : {DATA_W{1'b0}};
        end else begin
            fwd_hit_o     = 1'b0;
            ld_conflict_o = 1'b0;
            fwd_data_o    = {DATA_W{1'b0}};
        end
    end

endmodule
